// File: rtl/decade_count_monitor_if.sv
// Bus between a BCD stream source/observer and decade_count_monitor.
interface decade_count_monitor_if #(
    parameter int unsigned WRAP_W = 16,
    parameter int unsigned ERR_W  = 8
) ();
    logic [3:0]        count_in;
    logic              count_vld;
    logic              clr_stat;
    logic              locked;
    logic              tc_pulse;
    logic              err_pulse;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [3:0]        exp_out;

    // Source/observer side: drives the stream, reads status.
    modport master (
        output count_in, count_vld, clr_stat,
        input  locked, tc_pulse, err_pulse, err_sticky, err_cnt, wrap_cnt, exp_out
    );

    // Monitor side.
    modport slave (
        input  count_in, count_vld, clr_stat,
        output locked, tc_pulse, err_pulse, err_sticky, err_cnt, wrap_cnt, exp_out
    );
endinterface

// File: rtl/decade_count_monitor.sv
// Receive-side checker for a 0..9 wrapping BCD counter stream.
// Locks after LOCK_CNT consecutive correct increments, then reports
// sequence errors and legal 9->0 wraps with saturating statistics.
// Optional macro DCM_REPEAT_TOLERATE_EN: a legal repeat of the previous
// value is treated as a stall (no error, no progress) outside IDLE.
module decade_count_monitor #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned WRAP_W   = 16,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decade_count_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_prev;
    logic [3:0]         w_prev_nxt;
    logic [3:0]         r_match_cnt;
    logic [3:0]         w_match_nxt;
    logic [3:0]         w_match_inc;
    logic [3:0]         w_expected;
    logic               w_legal;
    logic               w_hit;
    logic               w_stall;
    logic               w_sample;
    logic               w_tc_evt;
    logic               w_err_evt;

    logic               r_locked;
    logic               r_tc_pulse;
    logic               r_err_pulse;
    logic               r_err_sticky;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [WRAP_W-1:0]  r_wrap_cnt;

    // Sample classification against the registered previous value.
    assign w_expected  = (r_prev == 4'd9) ? 4'd0 : r_prev + 4'd1;
    assign w_legal     = (bus.count_in <= 4'd9);
    assign w_hit       = w_legal && (bus.count_in == w_expected);
    assign w_match_inc = r_match_cnt + 4'd1;

`ifdef DCM_REPEAT_TOLERATE_EN
    // A repeated legal value outside IDLE is a source stall, not a sample.
    assign w_stall = w_legal && (r_state != ST_IDLE) && (bus.count_in == r_prev);
`else
    assign w_stall = 1'b0;
`endif

    assign w_sample = bus.count_vld && !w_stall;

    // State, previous value and match counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prev      <= 4'd0;
            r_match_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_match_cnt <= w_match_nxt;
        end
    end

    // Next-state logic for the lock FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_match_nxt = r_match_cnt;
        if (w_sample) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_legal) begin
                        w_prev_nxt  = bus.count_in;
                        w_match_nxt = 4'd0;
                        w_state_nxt = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!w_legal) begin
                        w_match_nxt = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end else if (w_hit) begin
                        w_prev_nxt = bus.count_in;
                        if (w_match_inc == 4'(LOCK_CNT)) begin
                            w_match_nxt = 4'd0;
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_prev_nxt  = bus.count_in;
                        w_match_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_hit) begin
                        w_prev_nxt = bus.count_in;
                    end else if (w_legal) begin
                        w_prev_nxt  = bus.count_in;
                        w_match_nxt = 4'd0;
                        w_state_nxt = ST_SYNC;
                    end else begin
                        w_match_nxt = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_match_nxt = 4'd0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Event decode: wraps and errors are only reported while locked.
    always_comb begin
        w_tc_evt  = 1'b0;
        w_err_evt = 1'b0;
        if (w_sample && (r_state == ST_LOCKED)) begin
            if (w_hit) begin
                w_tc_evt = (r_prev == 4'd9);
            end else begin
                w_err_evt = 1'b1;
            end
        end
    end

    // Registered status and saturating statistics; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked     <= 1'b0;
            r_tc_pulse   <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_wrap_cnt   <= '0;
        end else begin
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_tc_pulse  <= w_tc_evt;
            r_err_pulse <= w_err_evt;
            if (bus.clr_stat) begin
                r_err_sticky <= 1'b0;
                r_err_cnt    <= '0;
                r_wrap_cnt   <= '0;
            end else begin
                if (w_err_evt) begin
                    r_err_sticky <= 1'b1;
                end
                if (w_err_evt && (r_err_cnt != {ERR_W{1'b1}})) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
                if (w_tc_evt && (r_wrap_cnt != {WRAP_W{1'b1}})) begin
                    r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
                end
            end
        end
    end

    assign bus.locked     = r_locked;
    assign bus.tc_pulse   = r_tc_pulse;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.wrap_cnt   = r_wrap_cnt;
    assign bus.exp_out    = (r_state == ST_IDLE) ? 4'd0 : w_expected;

endmodule

// File: doc/decade_count_monitor.md
Name: decade_count_monitor

Overview:
- Receive-side checker for the 4-bit BCD stream produced by a decade counter (0..9, wrapping 9->0).
- Locks onto the stream, then flags every out-of-sequence or illegal value.
- Emits a one-cycle pulse on each legal 9->0 wrap and keeps saturating wrap and error statistics.
- Sits downstream of the counter, between it and status/debug logic.

Parameters:
LOCK_CNT, 3, consecutive correct increments required to enter LOCKED (legal range 1..15)
WRAP_W, 16, width of the wrap statistic counter
ERR_W, 8, width of the error statistic counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
count_in  input  4  observed counter value
count_vld  input  1  count_in is sampled on a rising clk edge only when this is high
clr_stat  input  1  synchronous clear of err_sticky, err_cnt and wrap_cnt
locked  output  1  high while the FSM is in LOCKED
tc_pulse  output  1  one-cycle pulse for each legal 9->0 wrap seen while LOCKED
err_pulse  output  1  one-cycle pulse for each sequence error seen while LOCKED
err_sticky  output  1  set by err_pulse, cleared only by clr_stat or reset
err_cnt  output  ERR_W  number of errors, saturating
wrap_cnt  output  WRAP_W  number of wraps, saturating
exp_out  output  4  next expected value (0 when in IDLE)

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, prev=0, match_cnt=0.
  - All outputs 0.
- Samples and gaps:
  - Only count_vld=1 cycles are samples.
  - count_vld=0 cycles hold all state and force pulses to 0.
  - Gaps of any length are legal.
- Expected value: expected = (prev==9) ? 0 : prev+1.
- Illegal value: count_in > 9 (10..15).
- Latency: every output is registered and reflects a sample one cycle after the sampling edge. Pulses last exactly one cycle.
- FSM, IDLE:
  - Legal sample: prev=sample, match_cnt=0, go to SYNC.
  - Illegal sample: stay in IDLE.
- FSM, SYNC:
  - Sample == expected: prev=sample, match_cnt+1. When match_cnt reaches LOCK_CNT, go to LOCKED and set match_cnt=0.
  - Legal sample != expected: prev=sample, match_cnt=0, stay in SYNC.
  - Illegal sample: go to IDLE.
  - No errors or wraps are reported outside LOCKED.
- FSM, LOCKED:
  - Sample == expected: prev=sample. If the transition is 9->0, tc_pulse=1 and wrap_cnt+1, saturating at all-ones.
  - Any other sample (including a repeat of prev): err_pulse=1, err_sticky=1, err_cnt+1 saturating, locked drops the next cycle.
    - Legal sample: prev=sample, match_cnt=0, go to SYNC.
    - Illegal sample: go to IDLE.
- clr_stat:
  - Clears err_sticky, err_cnt and wrap_cnt. Does not affect FSM, prev or exp_out.
  - If clr_stat and an error or wrap occur in the same cycle, the clear wins. The pulse still fires, but the counters and sticky flag end at 0.
- Width rules:
  - Counters saturate; they never wrap.
  - match_cnt is 4 bits.
  - exp_out is combinationally derived from registered prev and state.
- Reset mid-operation: immediately returns to the reset state, discarding lock and statistics.

Optional Feature:
- Macro: DCM_REPEAT_TOLERATE_EN.
- When defined:
  - A legal sample equal to prev is a stall.
  - In SYNC and LOCKED it causes no error, no state change, no match_cnt progress and no tc_pulse.
  - This supports sources with a clock enable.
- When undefined: a repeat is handled as a mismatch, exactly as described in Behaviour.

Test Plan:
- Lock: reset, then stream 4,5,6,7 with count_vld=1 every cycle -> locked rises 1 cycle after the sample 7 (3 matches). err_cnt=0.
- Wrap: once locked, stream 8,9,0,1 -> exactly one tc_pulse, 1 cycle after the 0 sample. wrap_cnt=1. No err_pulse.
- Error/relock: while locked with prev=3, send 6 -> err_pulse once, err_sticky=1, err_cnt=1, locked=0. Then send 7,8,9 -> locked=1 again.
- Illegal and gaps:
  - While locked, send 12 -> err_pulse, FSM goes to IDLE, exp_out=0.
  - Separately, insert 5-cycle count_vld=0 gaps in a correct stream -> no errors, lock held.
- Saturation/clear:
  - Force 300 errors with ERR_W=8 -> err_cnt=255.
  - Assert clr_stat in the same cycle as an error -> err_cnt=0, err_sticky=0, err_pulse=1.
- Repeat: send 5,5 while locked -> err_pulse without DCM_REPEAT_TOLERATE_EN; no pulse and locked held with it.
- Async reset: drop rst_n mid-stream -> locked, counters and pulses go to 0 without waiting for a clk edge.
